bus_cycle_sequencer: RTL and testbench
======================================

BUS_CYCLE_SEQUENCER -- requirements
Module: bus_cycle_sequencer

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state changes on posedge.
REQ-002 SHALL have port: rst_L  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: cyc_start  in  1  request one machine cycle.
REQ-004 SHALL have port: cyc_type  in  3  0=OCF, 1=MR, 2=MW, 3=PR, 4=PW; 5-7 illegal.
REQ-005 SHALL have ports: cyc_addr  in  16  cycle address; cyc_wdata  in  8  write data.
REQ-006 SHALL have ports: cyc_ready  out  1  start accepted this cycle; cyc_done  out  1  one-cycle completion pulse; cyc_rdata  out  8  captured read data; cyc_err  out  1  illegal-type pulse.
REQ-007 SHALL have ports: addr_out  out  16; addr_oe  out  1; data_out  out  8; data_oe  out  1; data_in  in  8.
REQ-008 SHALL have ports, all out 1, active-low: M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L.
REQ-009 SHALL have ports, both in 1, active-low: WAIT_L, BUSREQ_L.

Function
REQ-010 SHALL implement states IDLE, T1, T2, TW, T3, T4, GRANT; one state per clk.
REQ-011 cyc_ready SHALL = (state==IDLE or cyc_done) and BUSREQ_L==1.
REQ-012 Start SHALL be accepted on cyc_start & cyc_ready with legal type: latch type/addr/wdata, next state T1.
REQ-013 Accepting a start in the cyc_done cycle SHALL give back-to-back T1 with no IDLE gap.
REQ-014 Illegal type with cyc_start & cyc_ready SHALL pulse cyc_err one cycle, not be latched, and leave the bus idle.
REQ-015 At IDLE or the final T-state, BUSREQ_L==0 SHALL win over cyc_start; next state GRANT.
REQ-016 GRANT SHALL drive BUSACK_L=0, addr_oe=0, data_oe=0 and all strobes high, and SHALL return to IDLE the cycle after BUSREQ_L samples 1.
REQ-017 OCF SHALL run T1,T2,T3,T4: M1_L=0, MREQ_L=0, RD_L=0 in T1-T2; addr_out=latched addr in T1-T2.
REQ-018 OCF T3-T4 SHALL drive RFSH_L=0, MREQ_L=0, M1_L=1, RD_L=1, addr_out={9'b0, rfsh_cnt[6:0]}.
REQ-019 The 7-bit rfsh_cnt SHALL increment at the end of each OCF T4 and wrap 127->0.
REQ-020 MR SHALL run T1,T2,T3 with MREQ_L=0 and RD_L=0 throughout; cyc_done in T3.
REQ-021 MW SHALL run T1,T2,T3 with MREQ_L=0 and data_oe=1 in T1-T3, WR_L=0 in T2-T3; cyc_done in T3.
REQ-022 PR/PW SHALL run T1,T2,TW,T3 with one forced TW; IORQ_L=0 and RD_L (PR) or WR_L (PW)=0 in T2,TW,T3; PW data_oe=1 in T1-T3.
REQ-023 OCF SHALL assert cyc_done in T4.
REQ-024 WAIT_L SHALL be sampled at the end of T2 and each TW; 0 means enter or stay in TW, with strobes unchanged from T2.
REQ-025 The number of TW cycles SHALL be unbounded.
REQ-026 Read data SHALL be captured into cyc_rdata at the end of the last T2/TW cycle, i.e. the one where WAIT_L==1.
REQ-027 cyc_rdata SHALL hold its value until the next read capture.
REQ-028 addr_oe SHALL be 1 in T1-T4 and TW, and 0 in IDLE and GRANT.
REQ-029 In IDLE, addr_out and data_out SHALL hold their last values.

Reset
REQ-030 rst_L=0 SHALL asynchronously force state IDLE, rfsh_cnt=0, cyc_rdata=0, all *_L outputs=1, addr_oe=data_oe=0, addr_out=data_out=0, cyc_done=cyc_err=0.
REQ-031 Reset mid-cycle SHALL abort the cycle without cyc_done.
REQ-032 After rst_L rises, the first start SHALL be accepted on the first posedge with cyc_ready=1.

Verification
REQ-033 OCF addr 0x1234, data_in 0x3E, WAIT_L=1 -> M1_L/RD_L low 2 clk, RFSH addr 0x0000 for 2 clk, cyc_done at clk 4, cyc_rdata=0x3E, rfsh_cnt=1.
REQ-034 MR addr 0x8000 with WAIT_L=0 for 3 clk from T2 -> 3 TW states, data captured once WAIT_L=1, cyc_done at clk 6.
REQ-035 PW addr 0x00FE, wdata 0xA5, start held continuously -> IORQ_L/WR_L low 3 clk, done at clk 4, next T1 at clk 5 with no IDLE gap.
REQ-036 BUSREQ_L=0 together with cyc_start in IDLE -> GRANT, BUSACK_L=0, addr_oe=0, start not accepted; BUSREQ_L=1 -> IDLE, then start accepted.
REQ-037 128 OCFs -> rfsh_cnt wraps to 0; cyc_type=6 -> cyc_err one pulse, no strobes; rst_L low during MW T2 -> WR_L/MREQ_L high immediately, no cyc_done.

Source files
------------

// File: rtl/bus_cycle_sequencer.sv
// Bus cycle sequencer: turns single machine-cycle requests (opcode fetch, memory read/write,
// port read/write) into T-state strobe sequences with wait-state insertion, DRAM refresh
// addressing and bus-grant handling. Bus outputs are registered from the next-state decode
// so every strobe changes cleanly on the clock edge and is forced inactive by reset.
module bus_cycle_sequencer (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        cyc_start,
  input  logic [2:0]  cyc_type,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  cyc_wdata,
  output logic        cyc_ready,
  output logic        cyc_done,
  output logic [7:0]  cyc_rdata,
  output logic        cyc_err,
  output logic [15:0] addr_out,
  output logic        addr_oe,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        M1_L,
  output logic        MREQ_L,
  output logic        IORQ_L,
  output logic        RD_L,
  output logic        WR_L,
  output logic        RFSH_L,
  output logic        BUSACK_L,
  input  logic        WAIT_L,
  input  logic        BUSREQ_L
);

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3, StT4, StGrant} state_e;

  localparam logic [2:0] TypeOcf = 3'd0;
  localparam logic [2:0] TypeMr  = 3'd1;
  localparam logic [2:0] TypeMw  = 3'd2;
  localparam logic [2:0] TypePr  = 3'd3;
  localparam logic [2:0] TypePw  = 3'd4;

  state_e      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [6:0]  rfsh_cnt_q;
  logic [7:0]  rdata_q;
  logic        err_q, err_d;
  logic        final_cyc;
  logic        capture;
  logic        type_is_read;

  // Next-state bus signals, decoded from state_d/type_d
  logic        m1_d, mreq_d, iorq_d, rd_d, wr_d, rfsh_d, busack_d;
  logic        m1_q, mreq_q, iorq_q, rd_q, wr_q, rfsh_q, busack_q;
  logic        addr_oe_d, addr_oe_q, data_oe_d, data_oe_q;
  logic [15:0] addr_out_d, addr_out_q;
  logic [7:0]  data_out_d, data_out_q;
  logic        busy_d, t1_d, late_d;

  // Completion is combinational on the current T-state; OCF finishes in T4, others in T3
  assign cyc_done  = ((state_q == StT3) && (type_q != TypeOcf)) || (state_q == StT4);
  // A new request may be taken in IDLE or in the completion cycle (back-to-back)
  assign final_cyc = (state_q == StIdle) || cyc_done;
  assign cyc_ready = final_cyc && BUSREQ_L;

  assign type_is_read = (type_q == TypeOcf) || (type_q == TypeMr) || (type_q == TypePr);
  // Read data is taken on the last T2/TW, i.e. the edge that moves on to T3
  assign capture = ((state_q == StT2) || (state_q == StTw)) && (state_d == StT3) && type_is_read;

  // Next-state logic and request latching
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    if (final_cyc) begin
      state_d = StIdle;
      if (!BUSREQ_L) begin
        // Bus request has priority over any pending start
        state_d = StGrant;
      end else if (cyc_start) begin
        if (cyc_type <= TypePw) begin
          state_d = StT1;
          type_d  = cyc_type;
          addr_d  = cyc_addr;
          wdata_d = cyc_wdata;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        StT1: state_d = StT2;
        StT2: begin
          // Port cycles always get one wait state before WAIT_L is looked at
          if ((type_q == TypePr) || (type_q == TypePw) || !WAIT_L) state_d = StTw;
          else state_d = StT3;
        end
        StTw:    state_d = WAIT_L ? StT3 : StTw;
        StT3:    state_d = StT4;
        StGrant: state_d = BUSREQ_L ? StIdle : StGrant;
        default: state_d = StIdle;
      endcase
    end
  end

  // Bus output decode for the state being entered
  always_comb begin
    m1_d       = 1'b1;
    mreq_d     = 1'b1;
    iorq_d     = 1'b1;
    rd_d       = 1'b1;
    wr_d       = 1'b1;
    rfsh_d     = 1'b1;
    busack_d   = 1'b1;
    addr_oe_d  = 1'b0;
    data_oe_d  = 1'b0;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    busy_d     = (state_d == StT1) || (state_d == StT2) || (state_d == StTw) ||
                 (state_d == StT3) || (state_d == StT4);
    t1_d       = (state_d == StT1);
    late_d     = (state_d == StT3) || (state_d == StT4);
    if (state_d == StGrant) busack_d = 1'b0;
    if (busy_d) begin
      addr_oe_d  = 1'b1;
      addr_out_d = addr_d;
      case (type_d)
        TypeOcf: begin
          mreq_d = 1'b0;
          if (late_d) begin
            rfsh_d     = 1'b0;
            addr_out_d = {9'b0, rfsh_cnt_q};
          end else begin
            m1_d = 1'b0;
            rd_d = 1'b0;
          end
        end
        TypeMr: begin
          mreq_d = 1'b0;
          rd_d   = 1'b0;
        end
        TypeMw: begin
          mreq_d     = 1'b0;
          data_oe_d  = 1'b1;
          data_out_d = wdata_d;
          if (!t1_d) wr_d = 1'b0;
        end
        TypePr: begin
          if (!t1_d) begin
            iorq_d = 1'b0;
            rd_d   = 1'b0;
          end
        end
        TypePw: begin
          data_oe_d  = 1'b1;
          data_out_d = wdata_d;
          if (!t1_d) begin
            iorq_d = 1'b0;
            wr_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // State, latched request, refresh counter and read-data register
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= StIdle;
      type_q     <= TypeOcf;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      rfsh_cnt_q <= 7'd0;
      rdata_q    <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      if (state_q == StT4) rfsh_cnt_q <= rfsh_cnt_q + 7'd1;
      if (capture) rdata_q <= data_in;
    end
  end

  // Registered bus outputs
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      m1_q       <= 1'b1;
      mreq_q     <= 1'b1;
      iorq_q     <= 1'b1;
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      rfsh_q     <= 1'b1;
      busack_q   <= 1'b1;
      addr_oe_q  <= 1'b0;
      data_oe_q  <= 1'b0;
      addr_out_q <= 16'h0000;
      data_out_q <= 8'h00;
    end else begin
      m1_q       <= m1_d;
      mreq_q     <= mreq_d;
      iorq_q     <= iorq_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      rfsh_q     <= rfsh_d;
      busack_q   <= busack_d;
      addr_oe_q  <= addr_oe_d;
      data_oe_q  <= data_oe_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign M1_L      = m1_q;
  assign MREQ_L    = mreq_q;
  assign IORQ_L    = iorq_q;
  assign RD_L      = rd_q;
  assign WR_L      = wr_q;
  assign RFSH_L    = rfsh_q;
  assign BUSACK_L  = busack_q;
  assign addr_oe   = addr_oe_q;
  assign data_oe   = data_oe_q;
  assign addr_out  = addr_out_q;
  assign data_out  = data_out_q;
  assign cyc_rdata = rdata_q;
  assign cyc_err   = err_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer. Each request pushes the cyc_rdata value expected
// at its completion; a negedge monitor pops and compares on every cyc_done pulse.
module tb_bus_cycle_sequencer;

  localparam logic [2:0] OCF = 3'd0;
  localparam logic [2:0] MR  = 3'd1;
  localparam logic [2:0] MW  = 3'd2;
  localparam logic [2:0] PR  = 3'd3;
  localparam logic [2:0] PW  = 3'd4;

  logic        clk, rst_L, cyc_start;
  logic [2:0]  cyc_type;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_wdata;
  logic        cyc_ready, cyc_done, cyc_err;
  logic [7:0]  cyc_rdata;
  logic [15:0] addr_out;
  logic        addr_oe, data_oe;
  logic [7:0]  data_out, data_in;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L;
  logic        WAIT_L, BUSREQ_L;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0]  sb[$];
  logic [7:0]  sb_exp;
  logic [7:0]  model_rdata;
  logic [6:0]  model_rfsh;

  // Per-transaction trace
  int          tr_done, tr_m1, tr_mreq, tr_iorq, tr_rd, tr_wr, tr_rfsh, tr_doe;
  logic [15:0] tr_a1, tr_ar;
  logic [7:0]  tr_dout;
  bit          tr_ar_seen;

  bus_cycle_sequencer dut (
    .clk       (clk),
    .rst_L     (rst_L),
    .cyc_start (cyc_start),
    .cyc_type  (cyc_type),
    .cyc_addr  (cyc_addr),
    .cyc_wdata (cyc_wdata),
    .cyc_ready (cyc_ready),
    .cyc_done  (cyc_done),
    .cyc_rdata (cyc_rdata),
    .cyc_err   (cyc_err),
    .addr_out  (addr_out),
    .addr_oe   (addr_oe),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .data_in   (data_in),
    .M1_L      (M1_L),
    .MREQ_L    (MREQ_L),
    .IORQ_L    (IORQ_L),
    .RD_L      (RD_L),
    .WR_L      (WR_L),
    .RFSH_L    (RFSH_L),
    .BUSACK_L  (BUSACK_L),
    .WAIT_L    (WAIT_L),
    .BUSREQ_L  (BUSREQ_L)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] strobes();
    return {M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L, BUSACK_L};
  endfunction

  // Issue one request from a drive point and follow it to its done cycle (left there).
  // WAIT_L is held low for wl clocks starting at clock ws of the cycle (clock 1 = T1).
  task automatic run_txn(input logic [2:0] t, input logic [15:0] a, input logic [7:0] wd,
                         input logic [7:0] din, input int ws, input int wl, input bit hold);
    bit is_rd;
    is_rd     = (t == OCF) || (t == MR) || (t == PR);
    cyc_start = 1'b1;
    cyc_type  = t;
    cyc_addr  = a;
    cyc_wdata = wd;
    data_in   = din;
    WAIT_L    = 1'b1;
    sb.push_back(is_rd ? din : model_rdata);
    if (is_rd) model_rdata = din;
    tr_done = 0; tr_m1 = 0; tr_mreq = 0; tr_iorq = 0; tr_rd = 0; tr_wr = 0; tr_rfsh = 0;
    tr_doe = 0; tr_ar_seen = 1'b0; tr_ar = 16'hxxxx;
    tick();
    if (!hold) cyc_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      WAIT_L  = !(k >= ws && k < ws + wl);
      data_in = WAIT_L ? din : ~din;
      if (k == 1) begin
        tr_a1   = addr_out;
        tr_dout = data_out;
      end
      if (!M1_L)   tr_m1++;
      if (!MREQ_L) tr_mreq++;
      if (!IORQ_L) tr_iorq++;
      if (!RD_L)   tr_rd++;
      if (!WR_L)   tr_wr++;
      if (data_oe) tr_doe++;
      if (!RFSH_L) begin
        tr_rfsh++;
        if (!tr_ar_seen) tr_ar = addr_out;
        tr_ar_seen = 1'b1;
      end
      if (cyc_done) begin
        tr_done = k;
        break;
      end
      tick();
    end
    WAIT_L = 1'b1;
    if (t == OCF) begin
      check_val("rfsh_addr", tr_ar, {9'b0, model_rfsh});
      model_rfsh = model_rfsh + 7'd1;
    end
  endtask

  // Scoreboard: every completion must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_L && cyc_done) begin
      check_val("sb_pending", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        sb_exp = sb.pop_front();
        check_val("sb_rdata", cyc_rdata, sb_exp);
      end
    end
  end

  initial begin
    rst_L = 1'b0; cyc_start = 1'b0; cyc_type = 3'd0; cyc_addr = 16'h0; cyc_wdata = 8'h0;
    data_in = 8'h0; WAIT_L = 1'b1; BUSREQ_L = 1'b1;
    model_rdata = 8'h00; model_rfsh = 7'd0;
    tick(); tick();
    check_val("rst_strobes", strobes(), 7'h7F);
    check_val("rst_oe", {addr_oe, data_oe}, 2'b00);
    check_val("rst_addr_out", addr_out, 16'h0000);
    check_val("rst_data_out", data_out, 8'h00);
    check_val("rst_rdata", cyc_rdata, 8'h00);
    check_val("rst_done_err", {cyc_done, cyc_err}, 2'b00);
    rst_L = 1'b1;
    #1;
    check_val("rst_ready", cyc_ready, 1'b1);

    // Opcode fetch with refresh
    run_txn(OCF, 16'h1234, 8'h00, 8'h3E, 0, 0, 1'b0);
    check_val("ocf_done_clk", tr_done, 4);
    check_val("ocf_m1_clks", tr_m1, 2);
    check_val("ocf_rd_clks", tr_rd, 2);
    check_val("ocf_rfsh_clks", tr_rfsh, 2);
    check_val("ocf_mreq_clks", tr_mreq, 4);
    check_val("ocf_addr", tr_a1, 16'h1234);
    tick();
    check_val("ocf_idle_oe", addr_oe, 1'b0);
    check_val("ocf_idle_addr_hold", addr_out, 16'h0000);
    run_txn(OCF, 16'h4321, 8'h00, 8'h11, 0, 0, 1'b0);
    tick();

    // Memory read with three wait states
    run_txn(MR, 16'h8000, 8'h00, 8'h5C, 2, 3, 1'b0);
    check_val("mr_done_clk", tr_done, 6);
    check_val("mr_rd_clks", tr_rd, 6);
    check_val("mr_addr", tr_a1, 16'h8000);
    tick();

    // Memory write
    run_txn(MW, 16'h2222, 8'h77, 8'h00, 0, 0, 1'b0);
    check_val("mw_done_clk", tr_done, 3);
    check_val("mw_wr_clks", tr_wr, 2);
    check_val("mw_mreq_clks", tr_mreq, 3);
    check_val("mw_doe_clks", tr_doe, 3);
    check_val("mw_data_out", tr_dout, 8'h77);
    tick();
    check_val("mw_idle_data_hold", data_out, 8'h77);

    // Port read: one forced wait state
    run_txn(PR, 16'h0042, 8'h00, 8'hC3, 0, 0, 1'b0);
    check_val("pr_done_clk", tr_done, 4);
    check_val("pr_iorq_clks", tr_iorq, 3);
    check_val("pr_rd_clks", tr_rd, 3);
    tick();

    // Port write with start held: back-to-back second cycle
    run_txn(PW, 16'h00FE, 8'hA5, 8'h00, 0, 0, 1'b1);
    check_val("pw_done_clk", tr_done, 4);
    check_val("pw_iorq_clks", tr_iorq, 3);
    check_val("pw_wr_clks", tr_wr, 3);
    check_val("pw_ready_at_done", cyc_ready, 1'b1);
    sb.push_back(model_rdata);
    tick();
    cyc_start = 1'b0;
    check_val("b2b_t1_addr_oe", addr_oe, 1'b1);
    check_val("b2b_t1_addr", addr_out, 16'h00FE);
    check_val("b2b_t1_iorq", IORQ_L, 1'b1);
    begin
      int n;
      n = 1;
      while (!cyc_done && n < 20) begin
        tick();
        n++;
      end
      check_val("b2b_done_clk", n, 4);
    end
    tick();

    // Bus request beats a simultaneous start
    BUSREQ_L = 1'b0; cyc_start = 1'b1; cyc_type = MR; cyc_addr = 16'hBEEF;
    #1;
    check_val("grant_ready_low", cyc_ready, 1'b0);
    tick();
    check_val("grant_busack", BUSACK_L, 1'b0);
    check_val("grant_addr_oe", addr_oe, 1'b0);
    check_val("grant_strobes", strobes(), 7'h7E);
    tick();
    check_val("grant_hold", BUSACK_L, 1'b0);
    BUSREQ_L = 1'b1; cyc_start = 1'b0;
    tick();
    check_val("grant_release", BUSACK_L, 1'b1);
    check_val("grant_ready_again", cyc_ready, 1'b1);
    run_txn(MR, 16'hBEEF, 8'h00, 8'h99, 0, 0, 1'b0);
    check_val("post_grant_done_clk", tr_done, 3);
    tick();

    // Illegal type
    cyc_start = 1'b1; cyc_type = 3'd6;
    tick();
    cyc_start = 1'b0;
    check_val("err_pulse", cyc_err, 1'b1);
    check_val("err_strobes", strobes(), 7'h7F);
    check_val("err_addr_oe", addr_oe, 1'b0);
    tick();
    check_val("err_one_cycle", cyc_err, 1'b0);
    check_val("err_idle", addr_oe, 1'b0);

    // Refresh counter wrap: run fetches until the model counter wraps, then one more
    while (model_rfsh != 7'd0) begin
      run_txn(OCF, 16'h0100, 8'h00, 8'h01, 0, 0, 1'b0);
      tick();
    end
    run_txn(OCF, 16'h0200, 8'h00, 8'h02, 0, 0, 1'b0);
    check_val("rfsh_wrap", tr_ar, 16'h0000);
    tick();

    // Reset during memory write T2
    cyc_start = 1'b1; cyc_type = MW; cyc_addr = 16'h3333; cyc_wdata = 8'h44;
    tick();
    cyc_start = 1'b0;
    tick();
    check_val("mw_t2_wr", WR_L, 1'b0);
    rst_L = 1'b0;
    #1;
    check_val("abort_strobes", strobes(), 7'h7F);
    check_val("abort_oe", {addr_oe, data_oe}, 2'b00);
    check_val("abort_rdata", cyc_rdata, 8'h00);
    model_rdata = 8'h00;
    model_rfsh  = 7'd0;
    tick(); tick();
    rst_L = 1'b1;
    #1;
    check_val("abort_ready", cyc_ready, 1'b1);
    check_val("abort_no_done", cyc_done, 1'b0);
    run_txn(MR, 16'h0777, 8'h00, 8'h6D, 0, 0, 1'b0);
    check_val("post_rst_done_clk", tr_done, 3);
    tick();
    run_txn(OCF, 16'h0010, 8'h00, 8'h20, 0, 0, 1'b0);
    tick(); tick(); tick();
    check_val("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
